// File: rtl/pccard_host_cycle.sv
// pccard_host_cycle: 8-bit PC Card / CF host bus initiator with programmable setup/strobe/hold and WAIT stretch.
// Optional INPACK_n qualification of I/O reads is enabled by defining PCC_INPACK_CHECK_EN.
module pccard_host_cycle #(
   parameter int T_SETUP      = 2,
   parameter int T_STROBE     = 8,
   parameter int T_HOLD       = 2,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        clk_26,
   input  logic        rst_n,
   input  logic        req,
   input  logic [2:0]  cmd,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  rdata,
   output logic [15:0] A,
   output logic [7:0]  D_out,
   output logic        D_oe,
   input  logic [7:0]  D_in,
   output logic        CE1_n,
   output logic        CE2_n,
   output logic        REG_n,
   output logic        OE_n,
   output logic        WE_n,
   output logic        IORD_n,
   output logic        IOWR_n,
   input  logic        WAIT_n,
   input  logic        INPACK_n
);

`ifdef PCC_INPACK_CHECK_EN
   localparam bit INPACK_CHK = 1'b1;
`else
   localparam bit INPACK_CHK = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITX, HOLD} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [9:0]  wcnt_q, wcnt_d;
   logic [2:0]  cmd_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q, rdata_q;
   logic        wait_s1, wait_s2;
   logic        cyc_err_q, done_q, err_q;
   logic        start, rsv, fin, cap, tmo, ipk_bad;
   logic        is_rd, active, strobe_on;

   assign is_rd   = ~cmd_q[0];
   // A missing INPACK_n on an I/O read voids the captured byte.
   assign ipk_bad = INPACK_CHK && cap && (cmd_q == 3'b100) && INPACK_n;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      start   = 1'b0;
      rsv     = 1'b0;
      fin     = 1'b0;
      cap     = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (cmd[2:1] == 2'b11) begin
                  rsv = 1'b1;
               end else begin
                  start   = 1'b1;
                  cnt_d   = '0;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            if (cnt_q == 6'(T_SETUP - 1)) begin
               cnt_d   = '0;
               state_d = STROBE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         STROBE: begin
            if (cnt_q == 6'(T_STROBE - 1)) begin
               cnt_d = '0;
               if (!wait_s2) begin
                  wcnt_d  = '0;
                  state_d = WAITX;
               end else begin
                  cap     = is_rd;
                  state_d = HOLD;
               end
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         WAITX: begin
            // Release wins over timeout when both land on the same cycle.
            if (wait_s2) begin
               cap     = is_rd;
               state_d = HOLD;
            end else if (wcnt_q == 10'(WAIT_TIMEOUT - 1)) begin
               tmo     = 1'b1;
               state_d = HOLD;
            end else begin
               wcnt_d = wcnt_q + 10'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 6'(T_HOLD - 1)) begin
               fin     = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_26 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wcnt_q    <= '0;
         cmd_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wait_s1   <= 1'b1;
         wait_s2   <= 1'b1;
         cyc_err_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         wait_s1 <= WAIT_n;
         wait_s2 <= wait_s1;
         if (start) begin
            cmd_q     <= cmd;
            addr_q    <= addr;
            wdata_q   <= wdata;
            cyc_err_q <= 1'b0;
         end else if (tmo || ipk_bad) begin
            cyc_err_q <= 1'b1;
         end
         if (cap && !ipk_bad) rdata_q <= D_in;
         done_q <= fin | rsv;
         err_q  <= rsv | (fin & cyc_err_q);
      end
   end

   // Bus outputs decode straight from state so an async reset drops them at once.
   assign active    = (state_q != IDLE);
   assign strobe_on = (state_q == STROBE) || (state_q == WAITX);

   assign busy   = active;
   assign done   = done_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign A      = addr_q;
   assign D_out  = wdata_q;
   assign D_oe   = active & cmd_q[0];
   assign CE1_n  = ~active;
   assign CE2_n  = 1'b1;
   assign REG_n  = ~(active & ~cmd_q[1]);
   assign OE_n   = ~(strobe_on & ~cmd_q[2] & ~cmd_q[0]);
   assign WE_n   = ~(strobe_on & ~cmd_q[2] &  cmd_q[0]);
   assign IORD_n = ~(strobe_on &  cmd_q[2] & ~cmd_q[0]);
   assign IOWR_n = ~(strobe_on &  cmd_q[2] &  cmd_q[0]);

endmodule

// File: doc/pccard_host_cycle.md
Name: pccard_host_cycle

Overview:
- Host-side PC Card / CF bus initiator. Generates attribute-memory, common-memory and I/O read/write cycles toward a card through a single-request handshake.
- Drives address, data, CE/REG/strobe lines with programmable setup, strobe and hold timing; honours the card WAIT stretch.
- Returns read data or a timeout flag. Used as bench and bridge master against card-side logic such as the CIS ROM responder.
- 8-bit only: CE2_n is held high, so no 16-bit cycles.

Parameters:
- T_SETUP, 2: clk_26 cycles with address/CE/REG valid before the strobe asserts. Legal range 1..15.
- T_STROBE, 8: minimum strobe-low cycles. Legal range 2..63.
- T_HOLD, 2: cycles that address, CE, REG and write data stay valid after the strobe deasserts. Legal range 1..15.
- WAIT_TIMEOUT, 255: maximum cycles of WAIT_n low before the cycle is aborted. Legal range 1..1023.

Ports:
- clk_26  in  1  system clock, 26 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  start a cycle; sampled only in IDLE.
- cmd  in  3  cycle type: 000 attr rd, 001 attr wr, 010 mem rd, 011 mem wr, 100 io rd, 101 io wr; 11x reserved.
- addr  in  16  cycle address.
- wdata  in  8  write data.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at end of cycle.
- err  out  1  valid with done: 1 = timeout or reserved cmd.
- rdata  out  8  captured read data; holds until the next read completes.
- A  out  16  card address bus.
- D_out  out  8  write data to card.
- D_oe  out  1  host drives D.
- D_in  in  8  data from card.
- CE1_n  out  1  card enable, low byte.
- CE2_n  out  1  constant 1.
- REG_n  out  1  low for attr and io cycles.
- OE_n, WE_n, IORD_n, IOWR_n  out  1 each  active-low strobes.
- WAIT_n  in  1  card wait; low stretches the strobe.
- INPACK_n  in  1  card input acknowledge.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; busy=0; done=0; err=0; rdata=0; A=0; D_out=0; D_oe=0; CE1_n, CE2_n, REG_n, OE_n, WE_n, IORD_n, IOWR_n all 1.
- Reset mid-cycle: all strobes deassert immediately and no done pulse is issued.
- IDLE:
  - req=1 with a valid cmd: latch cmd/addr/wdata; busy=1 on the next cycle; go to SETUP.
  - req=1 with a reserved cmd: no bus activity; done=1 and err=1 on the next cycle; stay in IDLE.
- SETUP:
  - A, CE1_n=0 and REG_n are valid.
  - For writes, D_out is valid and D_oe=1 from the first SETUP cycle.
  - Stay T_SETUP cycles, then go to STROBE.
- STROBE:
  - The selected strobe is low: OE_n (attr/mem rd), WE_n (attr/mem wr), IORD_n (io rd), IOWR_n (io wr).
  - A counter runs T_STROBE cycles.
  - On the last count, if the registered WAIT_n = 0, go to WAITX; otherwise capture D_in (reads) and go to HOLD.
- WAITX:
  - Strobe stays low; the timeout counter increments each cycle.
  - WAIT_n sampled 1: go to HOLD the next cycle, capturing D_in on that transition.
  - Counter reaches WAIT_TIMEOUT: strobe deasserts, go to HOLD with err latched; rdata is not updated.
- HOLD:
  - Strobe is high; A, CE1_n, REG_n and D_out are held for T_HOLD cycles.
  - Then: CE1_n=1, REG_n=1, D_oe=0, done=1 for one cycle, busy=0, back to IDLE.
  - A retains its last value.
- WAIT_n is passed through a 2-flop synchronizer; its latency is accounted inside STROBE, and the added cycles are accepted.
- Throughput: a new req is accepted in the cycle after done. Minimum cycle length is T_SETUP+T_STROBE+T_HOLD+1 clocks.
- Strobes are never simultaneously low; OE_n/WE_n and IORD_n/IOWR_n are mutually exclusive at all times.
- req while busy is ignored.

Optional Feature:
- Macro PCC_INPACK_CHECK_EN.
- Defined: during io rd, INPACK_n is sampled on the last STROBE or WAITX cycle. If it is 1, err=1 at done and rdata is unchanged.
- Not defined: INPACK_n is ignored; the port is still present and unused.

Test Plan:
- Attr read: cmd=000, addr=0x0000, card returns 0x01, WAIT_n=1 → REG_n=0, OE_n low exactly 8 cycles after 2 setup cycles; done with rdata=0x01, err=0; total 13 cycles from req to done.
- IO write: cmd=101, addr=0x03F8, wdata=0xA5 → IOWR_n low 8 cycles; D_oe=1 and D_out=0xA5 from SETUP through HOLD; REG_n=0; err=0.
- WAIT stretch: mem read with WAIT_n held low 20 cycles → OE_n low 8+20+sync cycles; data captured after WAIT_n release; err=0.
- Timeout: WAIT_n stuck low, WAIT_TIMEOUT=16 → strobe released after 16 WAITX cycles; done with err=1; rdata unchanged from the previous value.
- Reset in STROBE: assert rst_n=0 mid-strobe → all strobes and CE1_n go high asynchronously; busy=0; no done pulse. With PCC_INPACK_CHECK_EN defined: io rd with INPACK_n=1 → err=1.
